// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: word-addressed memory front end with sub-word
// load extraction, read-modify-write sub-word stores and misalignment reporting.
module mem_access_unit (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign,
  output logic [7:0]  fault_count,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memWrite,
  output logic        mem_memRead,
  input  logic [31:0] mem_readData
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [0:0] {IDLE, RMW_WRITE} state_t;

  state_t              state, next_state;
  logic [DATA_W-1:0]   merge_word;
  logic [DATA_W-1:0]   lat_addr;
  logic [1:0]          lat_size;
  logic [HALF_W-1:0]   lat_wdata;
  logic                is_word_c, is_half_c, misaligned_c, start_rmw_c;
  logic [DATA_W-1:0]   shifted_c, merged_c;

  // Size 11 behaves as a word access.
  assign is_word_c    = req_size[1];
  assign is_half_c    = (req_size == 2'b01);
  assign misaligned_c = req_valid &&
                        ((is_word_c && (req_addr[1:0] != 2'b00)) ||
                         (is_half_c && req_addr[0]));

  // Read word shifted so the addressed lane sits at bit 0.
  assign shifted_c = mem_readData >> {req_addr[1:0], 3'b000};

  // Pending store data spliced into the word captured during the read cycle.
  always_comb begin
    merged_c = merge_word;
    if (lat_size == 2'b00)
      merged_c[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
    else
      merged_c[{lat_addr[1], 4'b0000} +: HALF_W] = lat_wdata;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next state and memory-side outputs; forced quiet while reset is low.
  always_comb begin
    next_state    = state;
    stall         = 1'b0;
    load_data     = '0;
    load_valid    = 1'b0;
    mem_address   = {req_addr[31:2], 2'b00};
    mem_writeData = '0;
    mem_memWrite  = 1'b0;
    mem_memRead   = 1'b0;
    start_rmw_c   = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE: begin
          if (req_valid && !misaligned_c) begin
            if (!req_write) begin
              mem_memRead = 1'b1;
              load_valid  = 1'b1;
              if (is_word_c)
                load_data = mem_readData;
              else if (is_half_c)
                load_data = {{HALF_W{req_signed & shifted_c[15]}}, shifted_c[15:0]};
              else
                load_data = {{24{req_signed & shifted_c[7]}}, shifted_c[7:0]};
            end else if (is_word_c) begin
              mem_memWrite  = 1'b1;
              mem_writeData = req_wdata;
            end else begin
              mem_memRead = 1'b1;
              stall       = 1'b1;
              start_rmw_c = 1'b1;
              next_state  = RMW_WRITE;
            end
          end
        end
        RMW_WRITE: begin
          mem_address   = {lat_addr[31:2], 2'b00};
          mem_writeData = merged_c;
          mem_memWrite  = 1'b1;
          next_state    = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Read-cycle capture for sub-word stores.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      merge_word <= '0;
      lat_addr   <= '0;
      lat_size   <= '0;
      lat_wdata  <= '0;
    end else if (start_rmw_c) begin
      merge_word <= mem_readData;
      lat_addr   <= req_addr;
      lat_size   <= req_size;
      lat_wdata  <= req_wdata[HALF_W-1:0];
    end
  end

  // Misalignment pulse and saturating fault counter.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      misalign    <= 1'b0;
      fault_count <= '0;
    end else begin
      misalign <= (state == IDLE) && misaligned_c;
      if ((state == IDLE) && misaligned_c && (fault_count != 8'hFF))
        fault_count <= fault_count + 8'd1;
    end
  end

endmodule
